// File: rtl/crc_code_controller_param_if.sv
// Bus between the CRC sequencing controller and the host/datapath.
//   write, read, crc_zero : requests from the host and syndrome status from the datapath
//   load_en, shift_en,
//   shift_cnt             : CRC register load/shift strobes and current shift index
//   write_mem_en          : store the data word plus CRC
//   read_valid, crc_error : result of a check, crc_error qualified by read_valid
//   busy, overrun         : controller active; a request was dropped
// The controller connects through the slave modport and the host through the master modport.
interface crc_code_controller_param_if #(
  parameter int CW = 5
);
  logic          write;
  logic          read;
  logic          crc_zero;
  logic          load_en;
  logic          shift_en;
  logic [CW-1:0] shift_cnt;
  logic          write_mem_en;
  logic          read_valid;
  logic          crc_error;
  logic          busy;
  logic          overrun;

  modport master (
    output write, read, crc_zero,
    input  load_en, shift_en, shift_cnt, write_mem_en, read_valid, crc_error, busy, overrun
  );

  modport slave (
    input  write, read, crc_zero,
    output load_en, shift_en, shift_cnt, write_mem_en, read_valid, crc_error, busy, overrun
  );
endinterface

// File: rtl/crc_code_controller_param.sv
// Sequencer for a bit-serial / multi-bit CRC datapath. It loads a word, shifts it
// N = DATA_WIDTH/BITS_PER_CYCLE times, then either writes word+CRC to memory (encode)
// or reports the syndrome check (decode). One request can wait in a pending slot
// while the controller is busy; any further request is dropped and flagged by overrun.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : slave side of crc_code_controller_param_if (width of shift_cnt must be CW)
//
// state   | meaning
// S_IDLE  | waiting for a write/read request edge
// S_LOAD  | one cycle of load_en
// S_SHIFT | N cycles of shift_en, shift_cnt counts 0..N-1
// S_WMEM  | one cycle of write_mem_en (encode finished)
// S_CHECK | one cycle of read_valid, crc_error = ~crc_zero (decode finished)
module crc_code_controller_param #(
  parameter int DATA_WIDTH     = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input logic                         clk,
  input logic                         rst,
  crc_code_controller_param_if.slave  bus
);

  localparam int BPC_SAFE = (BITS_PER_CYCLE < 1) ? 1 : BITS_PER_CYCLE;
  localparam int N        = DATA_WIDTH / BPC_SAFE;
  localparam int CW       = (N > 1) ? $clog2(N) : 1;

  if (BITS_PER_CYCLE < 1 || (DATA_WIDTH % BPC_SAFE) != 0) begin : g_bad_params
    $error("crc_code_controller_param: DATA_WIDTH must be a multiple of BITS_PER_CYCLE >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_WMEM,
    S_CHECK
  } state_t;

  localparam logic OP_WR = 1'b0;
  localparam logic OP_RD = 1'b1;

  state_t        state_q, state_d;
  logic          op_q, op_d;
  logic          pend_v_q, pend_v_d;
  logic          pend_op_q, pend_op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          write_q, read_q;
  logic          wr_arm_q, rd_arm_q;
  logic          load_q, shift_q, wmem_q, rv_q, busy_q, ovr_q;
  logic          ovr_d;

  logic wr_req, rd_req, finishing, serve_new, slot_free;

  // A level that is already high when reset releases must first drop before
  // its rising edge can count, so each input is armed once it has been seen low.
  assign wr_req = bus.write & ~write_q & wr_arm_q;
  assign rd_req = bus.read  & ~read_q  & rd_arm_q;

  assign finishing = (state_q == S_WMEM) || (state_q == S_CHECK);
  // Finishing with nothing pending behaves like IDLE, so a fresh request
  // starts straight away without a bubble in busy.
  assign serve_new = (state_q == S_IDLE) || (finishing && !pend_v_q);
  // The slot is consumed on the last WMEM/CHECK cycle, so it is free for a
  // request arriving in that same cycle.
  assign slot_free = !pend_v_q || finishing;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    pend_v_d  = pend_v_q;
    pend_op_d = pend_op_q;
    ovr_d     = 1'b0;
    cnt_d     = '0;

    if (serve_new) begin
      if (wr_req) begin
        state_d = S_LOAD;
        op_d    = OP_WR;
        if (rd_req) begin
          pend_v_d  = 1'b1;
          pend_op_d = OP_RD;
        end
      end else if (rd_req) begin
        state_d = S_LOAD;
        op_d    = OP_RD;
      end else if (finishing) begin
        state_d = S_IDLE;
      end
    end else begin
      case (state_q)
        S_LOAD:  state_d = S_SHIFT;
        S_SHIFT: begin
          if (cnt_q == CW'(N - 1)) state_d = (op_q == OP_WR) ? S_WMEM : S_CHECK;
        end
        S_WMEM, S_CHECK: begin
          state_d  = S_LOAD;
          op_d     = pend_op_q;
          pend_v_d = 1'b0;
        end
        default: state_d = S_IDLE;
      endcase

      if (wr_req && rd_req) begin
        // Write takes the slot if it is free; both overflow cases share one pulse.
        if (slot_free) begin
          pend_v_d  = 1'b1;
          pend_op_d = OP_WR;
        end
        ovr_d = 1'b1;
      end else if (wr_req || rd_req) begin
        if (slot_free) begin
          pend_v_d  = 1'b1;
          pend_op_d = rd_req ? OP_RD : OP_WR;
        end else begin
          ovr_d = 1'b1;
        end
      end
    end

    if (state_d == S_SHIFT && state_q == S_SHIFT) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      op_q      <= OP_WR;
      pend_v_q  <= 1'b0;
      pend_op_q <= OP_WR;
      cnt_q     <= '0;
      write_q   <= 1'b0;
      read_q    <= 1'b0;
      wr_arm_q  <= 1'b0;
      rd_arm_q  <= 1'b0;
      load_q    <= 1'b0;
      shift_q   <= 1'b0;
      wmem_q    <= 1'b0;
      rv_q      <= 1'b0;
      busy_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      pend_v_q  <= pend_v_d;
      pend_op_q <= pend_op_d;
      cnt_q     <= cnt_d;
      write_q   <= bus.write;
      read_q    <= bus.read;
      wr_arm_q  <= wr_arm_q | ~bus.write;
      rd_arm_q  <= rd_arm_q | ~bus.read;
      load_q    <= (state_d == S_LOAD);
      shift_q   <= (state_d == S_SHIFT);
      wmem_q    <= (state_d == S_WMEM);
      rv_q      <= (state_d == S_CHECK);
      busy_q    <= (state_d != S_IDLE);
      ovr_q     <= ovr_d;
    end
  end

  assign bus.load_en      = load_q;
  assign bus.shift_en     = shift_q;
  assign bus.shift_cnt    = cnt_q;
  assign bus.write_mem_en = wmem_q;
  assign bus.read_valid   = rv_q;
  // crc_zero is looked at only during the CHECK cycle itself.
  assign bus.crc_error    = rv_q & ~bus.crc_zero;
  assign bus.busy         = busy_q;
  assign bus.overrun      = ovr_q;

endmodule

// File: tb/tb_crc_code_controller_param.sv
module tb_crc_code_controller_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  crc_code_controller_param_if #(.CW(5)) bus_a ();
  crc_code_controller_param_if #(.CW(1)) bus_b ();

  crc_code_controller_param u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  crc_code_controller_param #(.DATA_WIDTH(8), .BITS_PER_CYCLE(8)) u_n1 (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int sel;
  int cyc;
  int n_load, n_shift, n_wmem, n_rv, n_err, n_ovr, n_busy, busy_rise;
  int first_load, last_load, first_shift, first_wmem, first_rv;
  int cnt_bad, excl_bad, err_bad, exp_cnt;
  logic prev_shift, prev_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    cyc = 0;
    n_load = 0; n_shift = 0; n_wmem = 0; n_rv = 0; n_err = 0; n_ovr = 0;
    n_busy = 0; busy_rise = 0;
    first_load = 0; last_load = 0; first_shift = 0; first_wmem = 0; first_rv = 0;
    cnt_bad = 0; excl_bad = 0; err_bad = 0; exp_cnt = 0;
    prev_shift = 1'b0; prev_busy = 1'b0;
  endtask

  // Steps n clocks, sampling the selected instance 1 ns after each rising edge.
  task automatic window(input int n);
    logic l, s, w, r, e, o, b;
    int c;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (sel == 0) begin
        l = bus_a.load_en; s = bus_a.shift_en; w = bus_a.write_mem_en; r = bus_a.read_valid;
        e = bus_a.crc_error; o = bus_a.overrun; b = bus_a.busy; c = int'(bus_a.shift_cnt);
      end else begin
        l = bus_b.load_en; s = bus_b.shift_en; w = bus_b.write_mem_en; r = bus_b.read_valid;
        e = bus_b.crc_error; o = bus_b.overrun; b = bus_b.busy; c = int'(bus_b.shift_cnt);
      end
      if (l) begin
        n_load++; last_load = cyc;
        if (first_load == 0) first_load = cyc;
      end
      if (s) begin
        n_shift++;
        if (first_shift == 0) first_shift = cyc;
        if (!prev_shift) exp_cnt = 0;
        if (c != exp_cnt) cnt_bad++;
        exp_cnt = exp_cnt + 1;
      end
      if (w) begin
        n_wmem++;
        if (first_wmem == 0) first_wmem = cyc;
      end
      if (r) begin
        n_rv++;
        if (first_rv == 0) first_rv = cyc;
        if (e) n_err++;
      end
      if (e && !r) err_bad++;
      if (o) n_ovr++;
      if (b) n_busy++;
      if (b && !prev_busy) busy_rise++;
      if ((int'(l) + int'(s) + int'(w) + int'(r)) > 1) excl_bad++;
      prev_shift = s;
      prev_busy  = b;
    end
  endtask

  task automatic sanity(input string tag);
    check({tag, "_cnt_seq"}, cnt_bad, 0);
    check({tag, "_exclusive"}, excl_bad, 0);
    check({tag, "_err_qual"}, err_bad, 0);
  endtask

  initial begin
    sel = 0;
    bus_a.write = 1'b0; bus_a.read = 1'b0; bus_a.crc_zero = 1'b1;
    bus_b.write = 1'b0; bus_b.read = 1'b0; bus_b.crc_zero = 1'b1;
    clear_stats();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs_a", {bus_a.load_en, bus_a.shift_en, bus_a.write_mem_en, bus_a.read_valid,
                            bus_a.crc_error, bus_a.busy, bus_a.overrun}, 0);
    check("rst_cnt_a", bus_a.shift_cnt, 0);
    check("rst_outputs_b", {bus_b.load_en, bus_b.shift_en, bus_b.write_mem_en, bus_b.read_valid,
                            bus_b.crc_error, bus_b.busy, bus_b.overrun}, 0);
    rst = 1'b1;
    window(3);

    // Single one-cycle write pulse
    clear_stats();
    bus_a.write = 1'b1;
    window(1);
    bus_a.write = 1'b0;
    window(39);
    check("t1_load", n_load, 1);
    check("t1_first_load", first_load, 1);
    check("t1_shift", n_shift, 32);
    check("t1_first_shift", first_shift, 2);
    check("t1_wmem", n_wmem, 1);
    check("t1_wmem_at", first_wmem, 34);
    check("t1_rv", n_rv, 0);
    check("t1_busy", n_busy, 34);
    check("t1_ovr", n_ovr, 0);
    sanity("t1");

    // Write held for two cycles: one operation
    clear_stats();
    bus_a.write = 1'b1;
    window(2);
    bus_a.write = 1'b0;
    window(40);
    check("t2_load", n_load, 1);
    check("t2_wmem", n_wmem, 1);
    check("t2_ovr", n_ovr, 0);
    check("t2_busy", n_busy, 34);

    // Read during write SHIFT, crc_zero=0
    clear_stats();
    bus_a.write = 1'b1;
    window(1);
    bus_a.write = 1'b0;
    window(5);
    bus_a.read = 1'b1;
    bus_a.crc_zero = 1'b0;
    window(1);
    bus_a.read = 1'b0;
    window(70);
    bus_a.crc_zero = 1'b1;
    check("t3_wmem_at", first_wmem, 34);
    check("t3_second_load", last_load, 35);
    check("t3_load", n_load, 2);
    check("t3_shift", n_shift, 64);
    check("t3_rv_at", first_rv, 68);
    check("t3_crc_error", n_err, 1);
    check("t3_busy", n_busy, 68);
    check("t3_busy_rise", busy_rise, 1);
    sanity("t3");

    // write, read, write while busy: third dropped
    clear_stats();
    bus_a.write = 1'b1;
    window(1);
    bus_a.write = 1'b0;
    window(3);
    bus_a.read = 1'b1;
    window(1);
    bus_a.read = 1'b0;
    window(3);
    bus_a.write = 1'b1;
    window(1);
    bus_a.write = 1'b0;
    window(70);
    check("t4_ovr", n_ovr, 1);
    check("t4_load", n_load, 2);
    check("t4_wmem", n_wmem, 1);
    check("t4_rv", n_rv, 1);
    check("t4_crc_error", n_err, 0);
    sanity("t4");

    // Two requests dropped in the same cycle: one overrun pulse
    clear_stats();
    bus_a.write = 1'b1;
    window(1);
    bus_a.write = 1'b0;
    window(3);
    bus_a.read = 1'b1;
    window(1);
    bus_a.read = 1'b0;
    window(3);
    bus_a.write = 1'b1;
    bus_a.read  = 1'b1;
    window(1);
    bus_a.write = 1'b0;
    bus_a.read  = 1'b0;
    window(70);
    check("t5_ovr", n_ovr, 1);
    check("t5_ops", n_wmem + n_rv, 2);

    // Request in the cycle the slot is consumed: refills, no overrun
    clear_stats();
    bus_a.write = 1'b1;
    window(1);
    bus_a.write = 1'b0;
    window(3);
    bus_a.read = 1'b1;
    window(1);
    bus_a.read = 1'b0;
    window(29);
    check("t6_in_wmem", bus_a.write_mem_en, 1);
    bus_a.write = 1'b1;
    window(1);
    bus_a.write = 1'b0;
    window(75);
    check("t6_ovr", n_ovr, 0);
    check("t6_load", n_load, 3);
    check("t6_last_load", last_load, 69);
    check("t6_wmem", n_wmem, 2);
    check("t6_rv", n_rv, 1);
    check("t6_busy", n_busy, 102);
    check("t6_busy_rise", busy_rise, 1);

    // Reset at shift_cnt=10 with a pending read
    clear_stats();
    bus_a.write = 1'b1;
    window(1);
    bus_a.write = 1'b0;
    window(2);
    bus_a.read = 1'b1;
    window(1);
    bus_a.read = 1'b0;
    window(8);
    check("t7_cnt_before_rst", bus_a.shift_cnt, 10);
    bus_a.write = 1'b1;
    rst = 1'b0;
    #1;
    check("t7_rst_strobes", {bus_a.load_en, bus_a.shift_en, bus_a.write_mem_en, bus_a.read_valid,
                             bus_a.crc_error, bus_a.overrun}, 0);
    check("t7_rst_busy", bus_a.busy, 0);
    check("t7_rst_cnt", bus_a.shift_cnt, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    clear_stats();
    window(50);
    check("t7_no_load", n_load, 0);
    check("t7_no_ops", n_wmem + n_rv, 0);
    check("t7_no_busy", n_busy, 0);
    bus_a.write = 1'b0;
    window(2);
    clear_stats();
    bus_a.write = 1'b1;
    window(1);
    bus_a.write = 1'b0;
    window(39);
    check("t7_new_load_at", first_load, 1);
    check("t7_new_wmem_at", first_wmem, 34);
    check("t7_new_rv", n_rv, 0);

    // N=1 instance: simultaneous write+read from IDLE
    sel = 1;
    clear_stats();
    bus_b.write = 1'b1;
    bus_b.read  = 1'b1;
    window(1);
    bus_b.write = 1'b0;
    bus_b.read  = 1'b0;
    window(10);
    check("t8_load", n_load, 2);
    check("t8_shift", n_shift, 2);
    check("t8_wmem_at", first_wmem, 3);
    check("t8_second_load", last_load, 4);
    check("t8_rv_at", first_rv, 6);
    check("t8_busy", n_busy, 6);
    check("t8_busy_rise", busy_rise, 1);
    check("t8_ovr", n_ovr, 0);
    sanity("t8");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/crc_code_controller_param.md
CRC_CODE_CONTROLLER_PARAM -- requirements
Module: crc_code_controller_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: codeword data bits processed per operation.
REQ-002 SHALL have parameter BITS_PER_CYCLE, default 1: bits the CRC datapath consumes per shift cycle.
REQ-003 SHALL have a derived localparam N = DATA_WIDTH/BITS_PER_CYCLE (shift cycles) and CW = max(1, $clog2(N)).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 write  input  1  encode request; a rising edge (0->1) is one request.
REQ-007 read  input  1  check/decode request; a rising edge is one request.
REQ-008 crc_zero  input  1  datapath syndrome is zero; sampled only in CHECK.
REQ-009 load_en  output  1  load data word into the CRC register.
REQ-010 shift_en  output  1  advance the CRC register by BITS_PER_CYCLE.
REQ-011 shift_cnt  output  CW  index of the current shift cycle, 0..N-1.
REQ-012 write_mem_en  output  1  write the data word plus CRC to memory.
REQ-013 read_valid  output  1  check result is valid this cycle.
REQ-014 crc_error  output  1  check failed; qualified by read_valid.
REQ-015 busy  output  1  controller is not in IDLE.
REQ-016 overrun  output  1  one-cycle pulse when a request is dropped.

Function
REQ-017 SHALL implement states IDLE, LOAD, SHIFT, WMEM and CHECK, plus an operation register op (WR or RD).
REQ-018 SHALL detect requests as write & ~write_q (and likewise for read) using registered copies; a level held high yields exactly one request.
REQ-019 IDLE: a write request -> LOAD with op=WR; a read request -> LOAD with op=RD; simultaneous requests -> write is served and read goes to the pending slot.
REQ-020 LOAD: load_en=1 for exactly one cycle; then -> SHIFT with shift_cnt=0.
REQ-021 SHIFT: shift_en=1 every cycle; shift_cnt increments; at shift_cnt==N-1 -> WMEM if op=WR, CHECK if op=RD. When N=1, SHIFT lasts one cycle.
REQ-022 WMEM: write_mem_en=1 for one cycle.
REQ-023 CHECK: read_valid=1 for one cycle, with crc_error = ~crc_zero.
REQ-024 After WMEM or CHECK: if the pending slot is full -> LOAD with op from the pending slot and the slot cleared; otherwise -> IDLE.
REQ-025 A request detected while busy SHALL fill a single-entry pending slot holding the op type, if the slot is empty.
REQ-026 A request detected while busy with the slot full SHALL be dropped with overrun=1 for one cycle; two requests dropped in the same cycle still give one pulse.
REQ-027 A request detected in the same cycle the slot is consumed (last cycle of WMEM/CHECK) SHALL fill the slot afresh and SHALL NOT overrun.
REQ-028 Latency: a request edge sampled at edge t0 gives load_en in cycle t0+1, shift_en in cycles t0+2..t0+N+1, and write_mem_en or read_valid in cycle t0+N+2.
REQ-029 busy SHALL be 1 in LOAD, SHIFT, WMEM and CHECK, and SHALL stay 1 without a gap through pending back-to-back operations.
REQ-030 load_en, shift_en, write_mem_en and read_valid SHALL be mutually exclusive and registered (glitch-free).
REQ-031 crc_error SHALL be 0 whenever read_valid=0.
REQ-032 Elaboration SHALL fail if DATA_WIDTH % BITS_PER_CYCLE != 0 or BITS_PER_CYCLE < 1.

Reset
REQ-033 rst=0 SHALL immediately force IDLE, clear op, the pending slot, shift_cnt, write_q and read_q, and drive all outputs to 0.
REQ-034 Reset mid-operation SHALL abort it: no write_mem_en or read_valid is produced, and the pending request is discarded.
REQ-035 After release, the first rising edge of write/read SHALL be detected only if the input was 0 at or after release; a level already high at release is not a request.

Verification
REQ-036 Defaults; single write pulse of one cycle -> load_en 1 cycle, shift_en 32 cycles with shift_cnt 0..31, write_mem_en 1 cycle, busy high for 34 cycles.
REQ-037 write held high for 2 cycles -> exactly one operation, no overrun.
REQ-038 A read issued during a write's SHIFT -> write_mem_en, then load_en on the next cycle, 32 shift cycles, then read_valid; busy stays high throughout; crc_zero=0 gives crc_error=1.
REQ-039 Three requests (write, read, write) while busy -> the 2nd is queued, the 3rd is dropped with a single overrun pulse, and exactly 2 operations complete.
REQ-040 DATA_WIDTH=8, BITS_PER_CYCLE=8 (N=1) -> 1 shift cycle; simultaneous write+read in IDLE -> write completes first, then read.
REQ-041 rst asserted at shift_cnt=10 with a pending read -> all outputs 0 immediately; after release, no operation occurs until a new request edge.
